// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, header nibble and one-hot index helper for the UART TX arbiter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  localparam logic [3:0] HDR_NIBBLE = 4'hA;
  function automatic logic [3:0] onehot_idx(input logic [7:0] oh);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching from the index after ptr
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  // scan farthest to nearest so the nearest requester after ptr wins
  always_comb begin
    gnt = '0;
    for (int i = N; i >= 1; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        gnt = '0;
        gnt[(int'(ptr) + i) % N] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-locked round-robin mux of byte requesters onto one external UART transmitter
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int G_NUM_REQ      = 4,
  parameter int G_WORD_WIDTH   = 8,
  parameter bit G_HEADER_EN    = 1'b1,
  parameter int G_BUSY_TIMEOUT = 8
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [G_NUM_REQ-1:0]              i_req_valid,
  input  logic [G_NUM_REQ*G_WORD_WIDTH-1:0] i_req_data,
  input  logic [G_NUM_REQ-1:0]              i_req_last,
  output logic [G_NUM_REQ-1:0]              o_req_ready,
  output logic                              o_tx_en,
  output logic [G_WORD_WIDTH-1:0]           o_tx_data,
  input  logic                              i_tx_busy,
  output logic [G_NUM_REQ-1:0]              o_grant,
  output logic                              o_pkt_done,
  output logic                              o_timeout
);
  localparam int PW = $clog2(G_NUM_REQ);
  localparam int CW = $clog2(G_BUSY_TIMEOUT + 1);

  state_t                  state, state_nx;
  logic [PW-1:0]           ptr;
  logic [G_NUM_REQ-1:0]    arb_gnt;
  logic [3:0]              gidx;
  logic [G_WORD_WIDTH-1:0] sel_data;
  logic [G_WORD_WIDTH-1:0] hdr_byte;
  logic [CW-1:0]           cnt;
  logic                    last_byte;
  logic                    fetch_ok;
  logic                    busy_expired;

  rr_arbiter #(.N(G_NUM_REQ), .PW(PW)) u_rr (
    .req(i_req_valid),
    .ptr(ptr),
    .gnt(arb_gnt)
  );

  assign gidx         = onehot_idx(8'(o_grant));
  assign sel_data     = i_req_data[gidx*G_WORD_WIDTH +: G_WORD_WIDTH];
  assign hdr_byte     = G_WORD_WIDTH'({HDR_NIBBLE, gidx});
  assign fetch_ok     = |(i_req_valid & o_grant);
  assign busy_expired = cnt == CW'(G_BUSY_TIMEOUT - 1);

  // next-state and the combinational byte-accept strobe
  always_comb begin
    state_nx    = state;
    o_req_ready = '0;
    case (state)
      IDLE:      state_nx = |i_req_valid ? (G_HEADER_EN ? HEADER : FETCH) : IDLE;
      HEADER:    state_nx = ISSUE;
      FETCH: begin
        o_req_ready = fetch_ok ? o_grant : '0;
        state_nx    = fetch_ok ? ISSUE : FETCH;
      end
      ISSUE:     state_nx = WAIT_BUSY;
      WAIT_BUSY: state_nx = i_tx_busy ? WAIT_DONE : (busy_expired ? IDLE : WAIT_BUSY);
      WAIT_DONE: state_nx = i_tx_busy ? WAIT_DONE : (last_byte ? IDLE : FETCH);
      default:   state_nx = IDLE;
    endcase
  end

  // state register, registered UART-side outputs and packet ownership
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      ptr        <= PW'(G_NUM_REQ - 1);
      o_grant    <= '0;
      o_tx_en    <= 1'b0;
      o_tx_data  <= '0;
      o_pkt_done <= 1'b0;
      o_timeout  <= 1'b0;
      last_byte  <= 1'b0;
      cnt        <= '0;
    end else begin
      state      <= state_nx;
      o_tx_en    <= state == ISSUE;
      o_pkt_done <= state == WAIT_DONE && !i_tx_busy && last_byte;
      cnt        <= state == WAIT_BUSY ? cnt + 1'b1 : '0;
      if (state == IDLE && |i_req_valid) begin
        o_grant <= arb_gnt;
        ptr     <= PW'(onehot_idx(8'(arb_gnt)));
      end
      if (state == HEADER) begin
        o_tx_data <= hdr_byte;
        last_byte <= 1'b0;
      end
      if (state == FETCH && fetch_ok) begin
        o_tx_data <= sel_data;
        last_byte <= |(i_req_last & o_grant);
      end
      if (state != IDLE && state_nx == IDLE) o_grant <= '0;
      if (state == WAIT_BUSY && state_nx == IDLE) o_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with requester queues and a behavioural UART busy model
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic [3:0]  grant;
  logic        pkt_done;
  logic        timeout;

  logic [8:0]  pq [4][$];
  logic [7:0]  exp_q[$];
  logic [7:0]  obs_q[$];
  int          checks = 0;
  int          fails = 0;
  int          done_cnt = 0;
  int          bcnt = 0;
  bit          busy_en = 1'b1;
  bit          rdy_err = 1'b0;

  uart_tx_arbiter dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .i_req_last(req_last), .o_req_ready(req_ready), .o_tx_en(tx_en), .o_tx_data(tx_data),
    .i_tx_busy(tx_busy), .o_grant(grant), .o_pkt_done(pkt_done), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      req_valid[k]      = pq[k].size() > 0;
      req_data[k*8 +: 8] = req_valid[k] ? pq[k][0][7:0] : 8'h00;
      req_last[k]       = req_valid[k] ? pq[k][0][8] : 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (req_ready[k] && pq[k].size() > 0) void'(pq[k].pop_front());
  end

  always @(negedge clk) begin
    if (pkt_done) done_cnt++;
    if ($countones(req_ready) > 1 || |(req_ready & ~grant)) rdy_err = 1'b1;
    if (tx_en) begin
      obs_q.push_back(tx_data);
      if (busy_en) bcnt = 4;
    end else if (bcnt > 0) bcnt--;
    tx_busy = bcnt > 0;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) pq[k].delete();
    repeat (6) @(negedge clk);
    rst = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks += 6;
    if (grant !== 4'h0)     begin fails++; $display("FAIL reset_grant got=%h exp=0", grant); end
    if (tx_en !== 1'b0)     begin fails++; $display("FAIL reset_tx_en got=%b exp=0", tx_en); end
    if (tx_data !== 8'h00)  begin fails++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
    if (pkt_done !== 1'b0)  begin fails++; $display("FAIL reset_pkt_done got=%b exp=0", pkt_done); end
    if (timeout !== 1'b0)   begin fails++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    if (req_ready !== 4'h0) begin fails++; $display("FAIL reset_ready got=%h exp=0", req_ready); end
  endtask

  task automatic test_single();
    int base;
    logic [7:0] o, e;
    do_reset();
    base = done_cnt;
    pq[0].push_back({1'b0, 8'h55});
    pq[0].push_back({1'b1, 8'h3C});
    exp_q.push_back(8'hA0); exp_q.push_back(8'h55); exp_q.push_back(8'h3C);
    for (int i = 0; i < 300 && done_cnt - base < 1; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt - base !== 1) begin fails++; $display("FAIL single_pkt_done got=%0d exp=1", done_cnt - base); end
    checks++;
    if (grant !== 4'h0) begin fails++; $display("FAIL single_grant_idle got=%h exp=0", grant); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL single_byte got=%h exp=%h", o, e); end
    end
    checks++;
    if (obs_q.size() != 0) begin fails++; $display("FAIL single_extra got=%0d exp=0", obs_q.size()); end
  endtask

  task automatic test_two();
    int base;
    logic [7:0] o, e;
    do_reset();
    base = done_cnt;
    pq[1].push_back({1'b0, 8'h11}); pq[1].push_back({1'b1, 8'h12});
    pq[2].push_back({1'b0, 8'h21}); pq[2].push_back({1'b1, 8'h22});
    exp_q.push_back(8'hA1); exp_q.push_back(8'h11); exp_q.push_back(8'h12);
    exp_q.push_back(8'hA2); exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    for (int i = 0; i < 600 && done_cnt - base < 2; i++) @(negedge clk);
    checks++;
    if (done_cnt - base !== 2) begin fails++; $display("FAIL two_pkt_done got=%0d exp=2", done_cnt - base); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL two_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_wrap();
    int base;
    logic [7:0] o, e;
    do_reset();
    base = done_cnt;
    pq[3].push_back({1'b1, 8'h33});
    exp_q.push_back(8'hA3); exp_q.push_back(8'h33);
    for (int i = 0; i < 300 && done_cnt - base < 1; i++) @(negedge clk);
    checks++;
    if (done_cnt - base !== 1) begin fails++; $display("FAIL wrap_first_done got=%0d exp=1", done_cnt - base); end
    pq[0].push_back({1'b1, 8'h01});
    pq[3].push_back({1'b1, 8'h34});
    exp_q.push_back(8'hA0); exp_q.push_back(8'h01);
    exp_q.push_back(8'hA3); exp_q.push_back(8'h34);
    for (int i = 0; i < 600 && done_cnt - base < 3; i++) @(negedge clk);
    checks++;
    if (done_cnt - base !== 3) begin fails++; $display("FAIL wrap_done got=%0d exp=3", done_cnt - base); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL wrap_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_pause();
    int base;
    logic [7:0] o, e;
    do_reset();
    base = done_cnt;
    pq[0].push_back({1'b0, 8'hB1});
    exp_q.push_back(8'hA0); exp_q.push_back(8'hB1);
    for (int i = 0; i < 300 && obs_q.size() < 2; i++) @(negedge clk);
    pq[1].push_back({1'b1, 8'hC1});
    repeat (20) @(negedge clk);
    checks += 3;
    if (grant !== 4'h1)        begin fails++; $display("FAIL pause_grant got=%h exp=1", grant); end
    if (obs_q.size() != 2)     begin fails++; $display("FAIL pause_bytes got=%0d exp=2", obs_q.size()); end
    if (pq[1].size() != 1)     begin fails++; $display("FAIL pause_req1_held got=%0d exp=1", pq[1].size()); end
    pq[0].push_back({1'b1, 8'hB2});
    exp_q.push_back(8'hB2); exp_q.push_back(8'hA1); exp_q.push_back(8'hC1);
    for (int i = 0; i < 600 && done_cnt - base < 2; i++) @(negedge clk);
    checks++;
    if (done_cnt - base !== 2) begin fails++; $display("FAIL pause_done got=%0d exp=2", done_cnt - base); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.size() > 0 ? obs_q.pop_front() : 8'hxx;
      checks++;
      if (o !== e) begin fails++; $display("FAIL pause_byte got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [7:0] o;
    do_reset();
    busy_en = 1'b0;
    pq[2].push_back({1'b1, 8'h77});
    n = 0;
    while (!tx_en && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (tx_en !== 1'b1) begin fails++; $display("FAIL timeout_tx_en got=%b exp=1", tx_en); end
    n = 0;
    while (!timeout && n < 50) begin @(negedge clk); n++; end
    checks += 2;
    if (n != 8)         begin fails++; $display("FAIL timeout_latency got=%0d exp=8", n); end
    if (grant !== 4'h0) begin fails++; $display("FAIL timeout_grant got=%h exp=0", grant); end
    repeat (30) @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin fails++; $display("FAIL timeout_sticky got=%b exp=1", timeout); end
    o = obs_q.size() > 0 ? obs_q[0] : 8'hxx;
    checks++;
    if (o !== 8'hA2) begin fails++; $display("FAIL timeout_hdr got=%h exp=a2", o); end
    busy_en = 1'b1;
    do_reset();
    checks++;
    if (timeout !== 1'b0) begin fails++; $display("FAIL timeout_clear got=%b exp=0", timeout); end
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    base = done_cnt;
    pq[1].push_back({1'b0, 8'hAA});
    pq[1].push_back({1'b1, 8'hBB});
    for (int i = 0; i < 300 && obs_q.size() < 1; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    pq[1].delete();
    @(negedge clk);
    checks += 6;
    if (grant !== 4'h0)     begin fails++; $display("FAIL mid_grant got=%h exp=0", grant); end
    if (tx_en !== 1'b0)     begin fails++; $display("FAIL mid_tx_en got=%b exp=0", tx_en); end
    if (tx_data !== 8'h00)  begin fails++; $display("FAIL mid_tx_data got=%h exp=00", tx_data); end
    if (pkt_done !== 1'b0)  begin fails++; $display("FAIL mid_pkt_done got=%b exp=0", pkt_done); end
    if (timeout !== 1'b0)   begin fails++; $display("FAIL mid_timeout got=%b exp=0", timeout); end
    if (req_ready !== 4'h0) begin fails++; $display("FAIL mid_ready got=%h exp=0", req_ready); end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks += 2;
    if (obs_q.size() != 1)   begin fails++; $display("FAIL mid_abandon got=%0d exp=1", obs_q.size()); end
    if (done_cnt != base)    begin fails++; $display("FAIL mid_no_done got=%0d exp=%0d", done_cnt, base); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two();
    test_wrap();
    test_pause();
    test_timeout();
    test_reset_mid();
    checks++;
    if (rdy_err !== 1'b0) begin fails++; $display("FAIL ready_rule got=%b exp=0", rdy_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter G_NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter G_WORD_WIDTH, default 8, byte width matching the UART.
REQ-003 SHALL have parameter G_HEADER_EN, default 1'b1: prepend a header byte per packet.
REQ-004 SHALL have parameter G_BUSY_TIMEOUT, default 8, max cycles from o_tx_en to i_tx_busy high.
REQ-005 SHALL have port i_clk  input  1  system clock.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_req_valid  input  G_NUM_REQ  per-requester byte valid.
REQ-008 SHALL have port i_req_data  input  G_NUM_REQ*G_WORD_WIDTH  per-requester byte, requester k at bits [k*W +: W].
REQ-009 SHALL have port i_req_last  input  G_NUM_REQ  marks final byte of packet.
REQ-010 SHALL have port o_req_ready  output  G_NUM_REQ  one-cycle byte-accept strobe.
REQ-011 SHALL have port o_tx_en  output  1  one-cycle transmit start pulse to the UART.
REQ-012 SHALL have port o_tx_data  output  G_WORD_WIDTH  byte to the UART, registered.
REQ-013 SHALL have port i_tx_busy  input  1  UART transmitter busy.
REQ-014 SHALL have port o_grant  output  G_NUM_REQ  one-hot owner of current packet, zero when idle.
REQ-015 SHALL have port o_pkt_done  output  1  one-cycle pulse after last byte of packet finishes.
REQ-016 SHALL have port o_timeout  output  1  sticky error: UART never went busy.

Function
REQ-017 SHALL implement FSM states IDLE, HEADER, FETCH, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-018 IDLE: if any i_req_valid, SHALL grant round-robin starting at index after last granter (index 0 after reset), register o_grant, go HEADER if G_HEADER_EN else FETCH.
REQ-019 HEADER: SHALL load o_tx_data = {4'hA, grant index zero-extended to 4 bits} (low W bits if W!=8), go ISSUE; no o_req_ready.
REQ-020 FETCH: if granted i_req_valid, SHALL assert o_req_ready[grant] one cycle, latch byte and i_req_last, go ISSUE; else hold in FETCH (packet lock, no re-arbitration).
REQ-021 ISSUE: SHALL assert o_tx_en exactly one cycle, go WAIT_BUSY.
REQ-022 WAIT_BUSY: SHALL go WAIT_DONE on i_tx_busy=1; if G_BUSY_TIMEOUT cycles elapse first, set o_timeout, clear o_grant, go IDLE.
REQ-023 WAIT_DONE: on i_tx_busy=0, SHALL go FETCH if the sent byte was header or non-last, else pulse o_pkt_done, clear o_grant, go IDLE.
REQ-024 At most one bit of o_req_ready SHALL be high per cycle, only for the granted index.
REQ-025 Requests from non-granted requesters during a packet SHALL be held off until packet end.
REQ-026 Round-robin pointer SHALL wrap from G_NUM_REQ-1 to 0.
REQ-027 o_timeout SHALL clear only on reset.
REQ-028 Latency IDLE-with-request to o_tx_en SHALL be 3 cycles with header, 3 cycles without (IDLE->FETCH->ISSUE, strobe in ISSUE's registered output).

Reset
REQ-029 On i_rst: state IDLE, o_req_ready=0, o_tx_en=0, o_tx_data=0, o_grant=0, o_pkt_done=0, o_timeout=0, RR pointer=G_NUM_REQ-1.
REQ-030 Reset mid-packet SHALL abandon the packet; no further bytes of it issued.

Structure
REQ-031 State enum and header nibble constant 4'hA SHALL live in shared package uart_pkg.
REQ-032 Round-robin selection SHALL be sub-module rr_arbiter (request vector, pointer in, one-hot grant out).
REQ-033 Block SHALL contain no UART instance; it drives an external uart.

Verification
REQ-034 Req0 sends 2-byte packet 0x55,0x3C (last on 2nd), header on -> UART sees 0xA0,0x55,0x3C, one o_pkt_done.
REQ-035 Req1 and req2 valid same cycle after reset -> req1 packet 0xA1.. completes fully before 0xA2.., no interleave.
REQ-036 Req3 completes, then req0 and req3 valid -> req0 granted (pointer wrap).
REQ-037 i_tx_busy tied low -> o_timeout high 8 cycles after o_tx_en, o_grant=0.
REQ-038 Granted requester deasserts valid mid-packet for 20 cycles -> FSM waits in FETCH, other requests ignored, packet resumes.
REQ-039 Assert i_rst during WAIT_DONE -> all outputs reset next cycle, no o_pkt_done.
